// File: rtl/des_iterative_ctrl.sv
// des_iterative_ctrl
// Iterative DES engine controller. A 64-bit block and a 64-bit key are taken
// over a valid/ready handshake. One Feistel round is computed per cycle for
// NUM_ROUNDS cycles, and the result is presented on data_out with out_valid.
// DES bit 1 is bit [63] of every vector.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   data_in/key/decrypt are valid
//   in_ready   engine can accept a block (IDLE only)
//   data_in    plaintext or ciphertext
//   key        DES key (parity bits are dropped by PC-1)
//   decrypt    0 = encrypt, 1 = decrypt, captured at acceptance
//   out_valid  data_out holds a finished result (DONE)
//   out_ready  consumer takes data_out
//   data_out   registered result after the final permutation
//   busy       high in ROUND or DONE
//   round      index of the round being computed, 0 outside ROUND
module des_iterative_ctrl #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] data_in,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy,
  output logic [3:0]  round
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} desState_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  // Permutation tables use DES numbering: entry n selects input bit n,
  // where bit 1 is the MSB.
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // S-boxes flattened as box*64 + row*16 + col.
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  // Permutations shift the selected bits in MSB first, so every index
  // stays at its natural width.
  function automatic logic [63:0] initPerm(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      idx = 6'(64 - IP_TAB[i]);
      y   = {y[62:0], x[idx]};
    end
    return y;
  endfunction

  function automatic logic [63:0] finalPerm(input logic [63:0] x);
    logic [63:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      idx = 6'(64 - FP_TAB[i]);
      y   = {y[62:0], x[idx]};
    end
    return y;
  endfunction

  function automatic logic [55:0] permChoice1(input logic [63:0] x);
    logic [55:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 56; i++) begin
      idx = 6'(64 - PC1_TAB[i]);
      y   = {y[54:0], x[idx]};
    end
    return y;
  endfunction

  function automatic logic [47:0] permChoice2(input logic [55:0] x);
    logic [47:0] y;
    logic [5:0]  idx;
    y = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 6'(56 - PC2_TAB[i]);
      y   = {y[46:0], x[idx]};
    end
    return y;
  endfunction

  // f(R,K): expand, mix with the subkey, substitute, then permute.
  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] mix;
    logic [31:0] sOut;
    logic [31:0] y;
    logic [5:0]  chunk;
    logic [8:0]  addr;
    logic [4:0]  idx;
    mix = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 5'(32 - E_TAB[i]);
      mix = {mix[46:0], r[idx]};
    end
    mix  = mix ^ k;
    sOut = '0;
    for (int b = 0; b < 8; b++) begin
      chunk = mix[47:42];
      mix   = {mix[41:0], 6'b0};
      addr  = {3'(b), chunk[5], chunk[0], chunk[4:1]};
      sOut  = {sOut[27:0], 4'(SBOX[addr])};
    end
    y = '0;
    for (int i = 0; i < 32; i++) begin
      idx = 5'(32 - P_TAB[i]);
      y   = {y[30:0], sOut[idx]};
    end
    return y;
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one position, all others by two.
  function automatic logic singleShift(input logic [4:0] i);
    return (i == 5'd1) || (i == 5'd2) || (i == 5'd9) || (i == 5'd16);
  endfunction

  desState_t   state_q, state_d;
  logic [31:0] left_q, right_q;
  logic [27:0] cHalf_q, dHalf_q;
  logic [3:0]  round_q;
  logic        dir_q;
  logic [63:0] dataOut_q;

  logic [4:0]  encShiftIdx, decShiftIdx;
  logic [27:0] cRotL, dRotL, cRotR, dRotR;
  logic [27:0] cNext, dNext;
  logic [47:0] roundKey;
  logic [31:0] leftNew, rightNew;
  logic        lastRound;

  // Key schedule. Encryption rotates left first and derives the subkey from
  // the rotated value; decryption uses the current value and then undoes the
  // matching encryption rotation, which walks the subkeys K16 down to K1.
  always_comb begin
    encShiftIdx = 5'({1'b0, round_q}) + 5'd1;
    decShiftIdx = 5'd16 - 5'({1'b0, round_q});
    if (singleShift(encShiftIdx)) begin
      cRotL = {cHalf_q[26:0], cHalf_q[27]};
      dRotL = {dHalf_q[26:0], dHalf_q[27]};
    end else begin
      cRotL = {cHalf_q[25:0], cHalf_q[27:26]};
      dRotL = {dHalf_q[25:0], dHalf_q[27:26]};
    end
    if (singleShift(decShiftIdx)) begin
      cRotR = {cHalf_q[0], cHalf_q[27:1]};
      dRotR = {dHalf_q[0], dHalf_q[27:1]};
    end else begin
      cRotR = {cHalf_q[1:0], cHalf_q[27:2]};
      dRotR = {dHalf_q[1:0], dHalf_q[27:2]};
    end
    if (dir_q) begin
      roundKey = permChoice2({cHalf_q, dHalf_q});
      cNext    = cRotR;
      dNext    = dRotR;
    end else begin
      roundKey = permChoice2({cRotL, dRotL});
      cNext    = cRotL;
      dNext    = dRotL;
    end
    leftNew   = right_q;
    rightNew  = left_q ^ feistel(right_q, roundKey);
    lastRound = (round_q == LAST_ROUND);
  end

  // Next-state decode. in_valid only matters in IDLE and out_ready only in
  // DONE, so a handshake in DONE can never start a new block.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ROUND;
      ROUND:   if (lastRound) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers. The block is loaded on acceptance, one round is
  // applied per ROUND cycle, and the last round captures FP of the swapped
  // halves so data_out stays stable through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_q    <= '0;
      right_q   <= '0;
      cHalf_q   <= '0;
      dHalf_q   <= '0;
      round_q   <= '0;
      dir_q     <= 1'b0;
      dataOut_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            {left_q, right_q}  <= initPerm(data_in);
            {cHalf_q, dHalf_q} <= permChoice1(key);
            dir_q              <= decrypt;
            round_q            <= '0;
          end
        end
        ROUND: begin
          left_q  <= leftNew;
          right_q <= rightNew;
          cHalf_q <= cNext;
          dHalf_q <= dNext;
          if (lastRound) begin
            round_q   <= '0;
            dataOut_q <= finalPerm({rightNew, leftNew});
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign round     = round_q;
  assign data_out  = dataOut_q;

endmodule

// File: tb/tb_des_iterative_ctrl.sv
// tb_des_iterative_ctrl
// Directed bench for des_iterative_ctrl using published DES vectors.
module tb_des_iterative_ctrl;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT2  = 64'h8787878787878787;
  localparam logic [63:0] CT2  = 64'h0000000000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [63:0] dataIn = '0;
  logic [63:0] keyIn = '0;
  logic        decryptIn = 1'b0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [63:0] dataOut;
  logic        busy;
  logic [3:0]  roundIdx;

  int checks = 0;
  int passes = 0;

  des_iterative_ctrl #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .data_in(dataIn), .key(keyIn), .decrypt(decryptIn),
    .out_valid(outValid), .out_ready(outReady),
    .data_out(dataOut), .busy(busy), .round(roundIdx)
  );

  always #5 clk = ~clk;

  // Hard stop in case a test loop is wrong.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one block and returns just after the
  // acceptance edge with in_valid dropped.
  task automatic applyStimulus(input logic [63:0] d, input logic [63:0] k,
                               input logic dec, output bit timedOut);
    int n = 0;
    while (!inReady && n < 50) begin
      tick();
      n++;
    end
    timedOut  = !inReady;
    dataIn    = d;
    keyIn     = k;
    decryptIn = dec;
    inValid   = 1'b1;
    tick();
    inValid   = 1'b0;
  endtask

  task automatic waitResult(input int limit, output int cycles, output bit timedOut);
    cycles = 0;
    while (!outValid && cycles < limit) begin
      tick();
      cycles++;
    end
    timedOut = !outValid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", inReady); else passes++;
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", outValid); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (roundIdx !== 4'd0) $display("[TB] FAIL reset_round: got %0d want 0", roundIdx); else passes++;
    checks++; if (dataOut !== 64'h0) $display("[TB] FAIL reset_data_out: got %h want 0", dataOut); else passes++;
    rst = 1'b0;
    tick();
  endtask

  // Encrypt vector 1 cycle by cycle: round index 0..15, then out_valid
  // exactly 16 edges after acceptance.
  task automatic test_encrypt;
    bit tmo;
    outReady = 1'b1;
    applyStimulus(PT1, KEY1, 1'b0, tmo);
    checks++; if (tmo !== 1'b0) $display("[TB] FAIL enc_accept_timeout: got %b want 0", tmo); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL enc_busy: got %b want 1", busy); else passes++;
    checks++; if (inReady !== 1'b0) $display("[TB] FAIL enc_in_ready: got %b want 0", inReady); else passes++;
    for (int r = 0; r < 16; r++) begin
      checks++; if (roundIdx !== 4'(r)) $display("[TB] FAIL enc_round_seq: got %0d want %0d", roundIdx, r); else passes++;
      checks++; if (outValid !== 1'b0) $display("[TB] FAIL enc_early_valid at round %0d: got %b want 0", r, outValid); else passes++;
      tick();
    end
    checks++; if (outValid !== 1'b1) $display("[TB] FAIL enc_latency: out_valid got %b want 1", outValid); else passes++;
    checks++; if (dataOut !== CT1) $display("[TB] FAIL enc_result: got %h want %h", dataOut, CT1); else passes++;
    checks++; if (roundIdx !== 4'd0) $display("[TB] FAIL enc_round_done: got %0d want 0", roundIdx); else passes++;
    tick();
    checks++; if (inReady !== 1'b1) $display("[TB] FAIL enc_back_idle: in_ready got %b want 1", inReady); else passes++;
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL enc_valid_clear: got %b want 0", outValid); else passes++;
  endtask

  task automatic test_decrypt;
    bit tmo;
    int cyc;
    outReady = 1'b1;
    applyStimulus(CT1, KEY1, 1'b1, tmo);
    waitResult(40, cyc, tmo);
    checks++; if (tmo !== 1'b0) $display("[TB] FAIL dec_timeout: got %b want 0", tmo); else passes++;
    checks++; if (cyc !== 16) $display("[TB] FAIL dec_latency: got %0d want 16", cyc); else passes++;
    checks++; if (dataOut !== PT1) $display("[TB] FAIL dec_result: got %h want %h", dataOut, PT1); else passes++;
    tick();
  endtask

  task automatic test_vector2;
    bit tmo;
    int cyc;
    outReady = 1'b1;
    applyStimulus(PT2, KEY2, 1'b0, tmo);
    waitResult(40, cyc, tmo);
    checks++; if (tmo !== 1'b0) $display("[TB] FAIL v2_enc_timeout: got %b want 0", tmo); else passes++;
    checks++; if (dataOut !== CT2) $display("[TB] FAIL v2_enc_result: got %h want %h", dataOut, CT2); else passes++;
    tick();
    applyStimulus(CT2, KEY2, 1'b1, tmo);
    waitResult(40, cyc, tmo);
    checks++; if (tmo !== 1'b0) $display("[TB] FAIL v2_dec_timeout: got %b want 0", tmo); else passes++;
    checks++; if (dataOut !== PT2) $display("[TB] FAIL v2_dec_result: got %h want %h", dataOut, PT2); else passes++;
    tick();
  endtask

  // Stalled consumer: DONE must hold with stable data while in_valid pulses
  // are ignored; a request presented with the release is only taken once
  // the engine is back in IDLE.
  task automatic test_backpressure;
    bit tmo;
    int cyc;
    outReady = 1'b0;
    applyStimulus(PT1, KEY1, 1'b0, tmo);
    waitResult(40, cyc, tmo);
    checks++; if (tmo !== 1'b0) $display("[TB] FAIL bp_timeout: got %b want 0", tmo); else passes++;
    for (int i = 0; i < 10; i++) begin
      inValid   = (i % 2 == 0);
      dataIn    = {$urandom, $urandom};
      keyIn     = {$urandom, $urandom};
      decryptIn = 1'($urandom);
      checks++; if (dataOut !== CT1) $display("[TB] FAIL bp_data_stable cycle %0d: got %h want %h", i, dataOut, CT1); else passes++;
      checks++; if (inReady !== 1'b0) $display("[TB] FAIL bp_in_ready cycle %0d: got %b want 0", i, inReady); else passes++;
      checks++; if (outValid !== 1'b1) $display("[TB] FAIL bp_out_valid cycle %0d: got %b want 1", i, outValid); else passes++;
      tick();
    end
    outReady  = 1'b1;
    inValid   = 1'b1;
    dataIn    = PT2;
    keyIn     = KEY2;
    decryptIn = 1'b0;
    tick();
    checks++; if (inReady !== 1'b1) $display("[TB] FAIL bp_release_idle: in_ready got %b want 1", inReady); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL bp_release_busy: got %b want 0", busy); else passes++;
    tick();
    inValid = 1'b0;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL bp_next_accept: busy got %b want 1", busy); else passes++;
    waitResult(40, cyc, tmo);
    checks++; if (cyc !== 16) $display("[TB] FAIL bp_next_latency: got %0d want 16", cyc); else passes++;
    checks++; if (dataOut !== CT2) $display("[TB] FAIL bp_next_result: got %h want %h", dataOut, CT2); else passes++;
    tick();
  endtask

  task automatic test_input_stability;
    bit tmo;
    int n = 0;
    outReady = 1'b1;
    applyStimulus(PT1, KEY1, 1'b0, tmo);
    while (!outValid && n < 40) begin
      dataIn    = {$urandom, $urandom};
      keyIn     = {$urandom, $urandom};
      decryptIn = 1'($urandom);
      inValid   = 1'($urandom);
      tick();
      n++;
    end
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1) $display("[TB] FAIL stab_timeout: out_valid got %b want 1", outValid); else passes++;
    checks++; if (dataOut !== CT1) $display("[TB] FAIL stab_result: got %h want %h", dataOut, CT1); else passes++;
    tick();
  endtask

  task automatic test_reset_mid_round;
    bit tmo;
    bit sawValid = 1'b0;
    int cyc;
    outReady = 1'b1;
    applyStimulus(PT1, KEY1, 1'b0, tmo);
    repeat (7) tick();
    checks++; if (roundIdx !== 4'd7) $display("[TB] FAIL rst_at_round7: got %0d want 7", roundIdx); else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (inReady !== 1'b1) $display("[TB] FAIL rst_mid_in_ready: got %b want 1", inReady); else passes++;
    checks++; if (outValid !== 1'b0) $display("[TB] FAIL rst_mid_out_valid: got %b want 0", outValid); else passes++;
    checks++; if (dataOut !== 64'h0) $display("[TB] FAIL rst_mid_data_out: got %h want 0", dataOut); else passes++;
    checks++; if (roundIdx !== 4'd0) $display("[TB] FAIL rst_mid_round: got %0d want 0", roundIdx); else passes++;
    repeat (25) begin
      tick();
      if (outValid) sawValid = 1'b1;
    end
    checks++; if (sawValid !== 1'b0) $display("[TB] FAIL rst_spurious_valid: got %b want 0", sawValid); else passes++;
    applyStimulus(PT1, KEY1, 1'b0, tmo);
    waitResult(40, cyc, tmo);
    checks++; if (dataOut !== CT1) $display("[TB] FAIL rst_fresh_result: got %h want %h", dataOut, CT1); else passes++;
    tick();
  endtask

  // in_valid held high with out_ready high: consecutive acceptances are
  // 18 edges apart.
  task automatic test_back_to_back;
    int  cnt = 0;
    bit  sawIdle = 1'b0;
    logic [63:0] firstResult = '1;
    bit  tmo;
    int  cyc;
    outReady  = 1'b1;
    dataIn    = CT2;
    keyIn     = KEY2;
    decryptIn = 1'b1;
    inValid   = 1'b1;
    tick();
    while (cnt < 40) begin
      tick();
      cnt++;
      if (outValid) firstResult = dataOut;
      if (!busy) sawIdle = 1'b1;
      else if (sawIdle) break;
    end
    inValid = 1'b0;
    checks++; if (cnt !== 18) $display("[TB] FAIL b2b_period: got %0d want 18", cnt); else passes++;
    checks++; if (firstResult !== PT2) $display("[TB] FAIL b2b_first_result: got %h want %h", firstResult, PT2); else passes++;
    waitResult(40, cyc, tmo);
    checks++; if (dataOut !== PT2) $display("[TB] FAIL b2b_second_result: got %h want %h", dataOut, PT2); else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_vector2();
    test_backpressure();
    test_input_stability();
    test_reset_mid_round();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/des_iterative_ctrl.md
# des_iterative_ctrl

Iterative DES engine controller: accepts a 64-bit block and 64-bit key over a valid/ready handshake and runs the shared Feistel round datapath once per cycle for 16 rounds. Owns the L/R and C/D state registers, the round counter, the subkey schedule direction and the FSM. Reuses the existing combinational initial/final permutation, PC-1, PC-2 and f-function blocks. Sits between the host-side register interface and the result capture logic. DES bit 1 is bit [63] throughout.

## Interface
- NUM_ROUNDS, 16, round count. Values other than 16 are for debug only and are not DES-compliant.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  data_in/key/decrypt valid
- in_ready  out  1  block can accept input; high only in IDLE
- data_in  in  64  plaintext or ciphertext
- key  in  64  DES key; parity bits are ignored by PC-1
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at acceptance
- out_valid  out  1  data_out valid
- out_ready  in  1  consumer accepts data_out
- data_out  out  64  result after FP, registered
- busy  out  1  high in ROUND or DONE
- round  out  4  index of the round being computed (0..15), 0 outside ROUND

## Operation
- FSM states: IDLE, ROUND, DONE. Clock is `clk`; reset is synchronous and active-high (`rst`).
- IDLE: in_ready=1. On in_valid&in_ready:
  - {L,R} <= IP(data_in)
  - {C,D} <= PC1(key)
  - latch decrypt into dir
  - round <= 0
  - go to ROUND
- Shift schedule s(i), i=1..16: s = 1 for i ∈ {1,2,9,16}; s = 2 otherwise.
- ROUND, encrypt, round index r (0-based, i=r+1):
  - CDn = {C,D} with each 28-bit half rotated left by s(i)
  - K = PC2(CDn)
  - {C,D} <= CDn
- ROUND, decrypt:
  - K = PC2({C,D}) using the current unrotated value
  - then {C,D} <= each half rotated right by s(16-r)
  - This yields the subkey order K16..K1.
- Every ROUND cycle:
  - L <= R
  - R <= L ^ f(R,K)
  - round <= round+1
- When round == NUM_ROUNDS-1:
  - data_out <= FP({R_new, L_new}), the final swap applied
  - go to DONE
  - round output returns to 0
- DONE: out_valid=1, with data_out held stable. On out_ready, go to IDLE and clear out_valid.
- Inputs are ignored outside IDLE. Changes to key/data_in/decrypt during ROUND have no effect.
- in_valid is never accepted in DONE, even when out_ready is high in the same cycle.
- After completion, {C,D} returns to PC1(key) in both directions (28 total shifts). This is not relied upon; each new block reloads it.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, round=0
  - data_out=0, L/R/C/D=0
- rst mid-ROUND or mid-DONE aborts the operation immediately: no out_valid pulse, and pending data is discarded.
- Acceptance edge A. Round edges are A+1..A+16. out_valid rises after edge A+16, so latency is 16 cycles from acceptance to out_valid.
- out_ready high during the first DONE cycle → IDLE after edge A+17. Next acceptance is possible at edge A+18. Peak throughput is 1 block per 18 cycles.
- out_ready low: DONE holds indefinitely, and in_ready stays 0.
- in_ready, out_valid and busy are decoded from registered state only. They have no combinational path from in_valid or out_ready.
- The f-function, PC2 and FP paths are combinational within one cycle. No multicycle paths.

## Test plan
- Encrypt: key=133457799BBCDFF1, data_in=0123456789ABCDEF, decrypt=0, out_ready=1 → data_out=85E813540F0AB405, out_valid 16 cycles after acceptance, round sequencing 0..15.
- Decrypt: same key, data_in=85E813540F0AB405, decrypt=1 → data_out=0123456789ABCDEF.
- Second vector: key=0E329232EA6D0D73, data_in=8787878787878787, encrypt → 0000000000000000; then decrypt back → 8787878787878787.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: data_out stable, in_ready=0 throughout, in_valid pulses ignored.
  - Release out_ready → next accept 2 cycles later.
- Input stability: toggle key and data_in randomly during ROUND → result still 85E813540F0AB405 for the first vector.
- Reset: assert rst at round=7 for 1 cycle.
  - Required: next cycle state=IDLE, in_ready=1, out_valid=0, data_out=0, and no spurious out_valid afterwards.
  - A fresh encrypt then completes correctly.
